// File: rtl/dac_frame_seq.sv
// Frame sequencer for the serial DAC write engine: fetches command bytes from a
// synchronous ROM, frames each one with an active-low chip select and spaces frames apart.
module dac_frame_seq #(
    parameter int ROM_AW  = 4,
    parameter int BITS    = 8,
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 32
) (
    input  logic              clk_cs,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [ROM_AW-1:0] start_addr,
    input  logic [ROM_AW:0]   frame_len,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        instrom,
    output logic              cs_o,
    input  logic [3:0]        waddr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROM_AW:0]   frame_cnt
);

    localparam int CW = $clog2(TMO_CYC + GAP_CYC + 1);
    localparam logic [3:0]    BITS_W   = 4'(BITS);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, GAP, DONE} state_t;

    state_t            state, state_nxt;
    logic [ROM_AW-1:0] rom_addr_nxt, addr_lat, addr_lat_nxt;
    logic [7:0]        instrom_nxt;
    logic              cs_nxt, done_nxt, err_nxt;
    logic [ROM_AW:0]   frame_cnt_nxt, remaining, remaining_nxt, len_lat, len_lat_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk_cs or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            addr_lat  <= '0;
            instrom   <= '0;
            cs_o      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
            remaining <= '0;
            len_lat   <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= rom_addr_nxt;
            addr_lat  <= addr_lat_nxt;
            instrom   <= instrom_nxt;
            cs_o      <= cs_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            frame_cnt <= frame_cnt_nxt;
            remaining <= remaining_nxt;
            len_lat   <= len_lat_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // One counter serves as the SEND watchdog and the GAP timer; it is cleared on entry to each.
    always_comb begin
        state_nxt     = state;
        rom_addr_nxt  = rom_addr;
        addr_lat_nxt  = addr_lat;
        instrom_nxt   = instrom;
        cs_nxt        = cs_o;
        done_nxt      = 1'b0;
        err_nxt       = err;
        frame_cnt_nxt = frame_cnt;
        remaining_nxt = remaining;
        len_lat_nxt   = len_lat;
        cnt_nxt       = cnt;

        if (abort) begin
            state_nxt = IDLE;
            cs_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cs_nxt = 1'b1;
                    if (start) begin
                        err_nxt = 1'b0;
                        if (frame_len != '0) begin
                            remaining_nxt = frame_len;
                            len_lat_nxt   = frame_len;
                            addr_lat_nxt  = start_addr;
                            rom_addr_nxt  = start_addr;
                            frame_cnt_nxt = '0;
                            state_nxt     = FETCH;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                FETCH: state_nxt = LOAD;
                LOAD: begin
                    instrom_nxt = rom_data;
                    cs_nxt      = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = SEND;
                end
                SEND: begin
                    if (waddr == BITS_W) begin
                        cs_nxt        = 1'b1;
                        frame_cnt_nxt = frame_cnt + 1'b1;
                        remaining_nxt = remaining - 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = GAP;
                    end else if (cnt == TMO_LAST) begin
                        err_nxt   = 1'b1;
                        cs_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (remaining != '0) begin
                            rom_addr_nxt = rom_addr + 1'b1;
                            state_nxt    = FETCH;
                        end else if (loop_en) begin
                            remaining_nxt = len_lat;
                            frame_cnt_nxt = '0;
                            rom_addr_nxt  = addr_lat;
                            state_nxt     = FETCH;
                        end else begin
                            state_nxt = DONE;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_seq.sv
// Directed bench for dac_frame_seq: ROM and serial-engine models plus a scoreboard
// of expected frame bytes, gap lengths and frame counts checked at every cs_o fall.
module tb_dac_frame_seq;

    localparam int ROM_AW  = 4;
    localparam int BITS    = 8;
    localparam int GAP_CYC = 2;
    localparam int TMO_CYC = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              loop_en = 1'b0;
    logic [ROM_AW-1:0] start_addr = '0;
    logic [ROM_AW:0]   frame_len = '0;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data = '0;
    logic [7:0]        instrom;
    logic              cs_o;
    logic [3:0]        waddr;
    logic              busy, done, err;
    logic [ROM_AW:0]   frame_cnt;
    logic              wd_en = 1'b1;
    logic [7:0]        rom [16];

    typedef struct {
        logic [7:0] data;
        int         hi_len;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;
    int   done_cnt = 0;
    int   fall_cnt = 0;
    int   hi_run = 0;
    logic prev_cs = 1'b1;
    int   n, d0, f0;

    dac_frame_seq #(.ROM_AW(ROM_AW), .BITS(BITS), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk_cs(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
        .start_addr(start_addr), .frame_len(frame_len), .rom_addr(rom_addr),
        .rom_data(rom_data), .instrom(instrom), .cs_o(cs_o), .waddr(waddr),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Serial engine model: bit counter runs while cs_o is low and parks at BITS.
    always @(posedge clk or negedge rst) begin
        if (!rst) waddr <= 4'd0;
        else if (cs_o) waddr <= 4'd0;
        else if (wd_en && waddr != 4'(BITS)) waddr <= waddr + 4'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [7:0] d, input int h, input int c);
        exp_t e;
        e.data = d;
        e.hi_len = h;
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [ROM_AW-1:0] a, input logic [ROM_AW:0] l, input logic lp);
        @(posedge clk);
        #1;
        start_addr = a;
        frame_len = l;
        loop_en = lp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitSig(input int which, input logic val, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (((which == 0) ? cs_o : done) == val) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Scoreboard side: each falling cs_o must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst) begin
            prev_cs = 1'b1;
            hi_run = 0;
        end else begin
            if (done) done_cnt++;
            if (prev_cs && !cs_o) begin
                fall_cnt++;
                checkOutput("sb_empty_at_fall", 32'(sb_q.size() == 0), 0);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    checkOutput("frame_byte", 32'(instrom), 32'(mon_e.data));
                    checkOutput("frame_cnt_at_fall", 32'(frame_cnt), mon_e.cnt);
                    if (mon_e.hi_len >= 0) checkOutput("cs_high_gap", hi_run, mon_e.hi_len);
                end
                hi_run = 0;
            end else if (cs_o) begin
                hi_run++;
            end
            prev_cs = cs_o;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'(8'h40 + i);
        rom[3]  = 8'hAD;
        rom[15] = 8'h11;
        rom[0]  = 8'h22;
        rom[1]  = 8'h33;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_cs_o", 32'(cs_o), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 0);
        checkOutput("rst_instrom", 32'(instrom), 0);
        checkOutput("rst_rom_addr", 32'(rom_addr), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single frame
        $display("[TB] single frame");
        d0 = done_cnt;
        pushExp(8'hAD, -1, 0);
        applyStimulus(4'd3, 5'd1, 1'b0);
        checkOutput("single_rom_addr", 32'(rom_addr), 3);
        waitSig(0, 1'b0, 10, n);
        checkOutput("single_cs_fall_latency", n, 3);
        waitSig(0, 1'b1, 40, n);
        checkOutput("single_cs_low_len", n, BITS + 1);
        waitSig(1, 1'b1, 10, n);
        checkOutput("single_done_latency", n, GAP_CYC + 1);
        checkOutput("single_frame_cnt", 32'(frame_cnt), 1);
        checkOutput("single_busy_after", 32'(busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("single_done_pulses", done_cnt - d0, 1);

        // Address wrap
        $display("[TB] address wrap");
        d0 = done_cnt;
        pushExp(8'h11, -1, 0);
        pushExp(8'h22, GAP_CYC + 2, 1);
        pushExp(8'h33, GAP_CYC + 2, 2);
        applyStimulus(4'd15, 5'd3, 1'b0);
        waitSig(1, 1'b1, 100, n);
        checkOutput("wrap_done_seen", 32'(n > 0), 1);
        checkOutput("wrap_frame_cnt", 32'(frame_cnt), 3);
        repeat (3) @(negedge clk);
        checkOutput("wrap_done_pulses", done_cnt - d0, 1);
        checkOutput("wrap_sb_left", sb_q.size(), 0);

        // Loop
        $display("[TB] loop");
        d0 = done_cnt;
        f0 = fall_cnt;
        for (int k = 0; k < 3; k++) begin
            pushExp(8'h45, (k == 0) ? -1 : GAP_CYC + 2, 0);
            pushExp(8'h46, GAP_CYC + 2, 1);
        end
        applyStimulus(4'd5, 5'd2, 1'b1);
        for (int i = 0; i < 300 && fall_cnt < f0 + 5; i++) @(negedge clk);
        checkOutput("loop_fifth_frame_seen", fall_cnt - f0, 5);
        @(posedge clk);
        #1 loop_en = 1'b0;
        waitSig(1, 1'b1, 200, n);
        checkOutput("loop_done_seen", 32'(n > 0), 1);
        checkOutput("loop_frame_cnt", 32'(frame_cnt), 2);
        repeat (3) @(negedge clk);
        checkOutput("loop_done_pulses", done_cnt - d0, 1);
        checkOutput("loop_frames", fall_cnt - f0, 6);

        // Timeout
        $display("[TB] timeout");
        d0 = done_cnt;
        wd_en = 1'b0;
        pushExp(8'hAD, -1, 0);
        applyStimulus(4'd3, 5'd1, 1'b0);
        waitSig(0, 1'b0, 10, n);
        checkOutput("tmo_cs_fall_latency", n, 3);
        waitSig(0, 1'b1, 60, n);
        checkOutput("tmo_send_len", n, TMO_CYC);
        checkOutput("tmo_err", 32'(err), 1);
        checkOutput("tmo_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        checkOutput("tmo_err_sticky", 32'(err), 1);
        checkOutput("tmo_no_done", done_cnt - d0, 0);
        wd_en = 1'b1;
        pushExp(8'hAD, -1, 0);
        applyStimulus(4'd3, 5'd1, 1'b0);
        checkOutput("tmo_err_cleared", 32'(err), 0);
        waitSig(1, 1'b1, 60, n);
        checkOutput("tmo_recover_done", 32'(n > 0), 1);

        // Abort during second frame
        $display("[TB] abort");
        f0 = fall_cnt;
        pushExp(8'h48, -1, 0);
        pushExp(8'h49, GAP_CYC + 2, 1);
        applyStimulus(4'd8, 5'd3, 1'b0);
        for (int i = 0; i < 100 && fall_cnt < f0 + 2; i++) @(negedge clk);
        checkOutput("abort_second_frame_seen", fall_cnt - f0, 2);
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_cs_o", 32'(cs_o), 1);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_frame_cnt", 32'(frame_cnt), 1);
        checkOutput("abort_instrom_hold", 32'(instrom), 32'h49);
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abort_no_done", done_cnt - d0, 0);
        checkOutput("abort_no_more_frames", fall_cnt - f0, 2);

        // Empty burst
        $display("[TB] empty burst");
        d0 = done_cnt;
        f0 = fall_cnt;
        applyStimulus(4'd2, 5'd0, 1'b0);
        waitSig(1, 1'b1, 10, n);
        checkOutput("empty_done_latency", n, 2);
        repeat (3) @(negedge clk);
        checkOutput("empty_no_frames", fall_cnt - f0, 0);
        checkOutput("empty_done_pulses", done_cnt - d0, 1);

        // Reset mid-SEND
        $display("[TB] reset mid-send");
        pushExp(8'hAD, -1, 0);
        applyStimulus(4'd3, 5'd1, 1'b0);
        waitSig(0, 1'b0, 10, n);
        checkOutput("rstmid_cs_fall", n, 3);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("rstmid_cs_o", 32'(cs_o), 1);
        checkOutput("rstmid_busy", 32'(busy), 0);
        checkOutput("rstmid_instrom", 32'(instrom), 0);
        checkOutput("rstmid_frame_cnt", 32'(frame_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dac_frame_seq.md
Name: dac_frame_seq

Overview:
- Sequencer for the serial DAC write engine (`wdata`).
- Fetches command bytes from a synchronous instruction ROM and presents each byte on `instrom`.
- Drops `cs_o` low to start each serial frame, watches `waddr` for end-of-frame, then raises `cs_o` and inserts an inter-frame gap.
- Runs a programmable burst of frames, optionally looping, with abort and watchdog timeout.

Parameters:
- ROM_AW, 4, ROM address width; addresses wrap modulo 2^ROM_AW.
- BITS, 8, `waddr` value that marks frame complete.
- GAP_CYC, 2, number of cycles `cs_o` is held high between frames (>=1).
- TMO_CYC, 32, maximum cycles in SEND before timeout.

Ports:
- clk_cs  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- abort  in  1  level; forces return to IDLE.
- loop_en  in  1  restart at start_addr after the last frame; sampled at end of each burst.
- start_addr  in  ROM_AW  first ROM address of the burst.
- frame_len  in  ROM_AW+1  number of frames in the burst; 0 = empty burst.
- rom_addr  out  ROM_AW  ROM read address (registered).
- rom_data  in  8  ROM read data, valid 1 cycle after rom_addr.
- instrom  out  8  byte to `wdata`; registered.
- cs_o  out  1  frame chip select to `wdata`, active-low.
- waddr  in  4  bit counter from `wdata`.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse when a burst ends normally.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- frame_cnt  out  ROM_AW+1  frames completed in the current burst.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, cs_o=1, instrom=0, rom_addr=0.
  - busy=0, done=0, err=0, frame_cnt=0.
  - Internal remaining-frame count and gap counter = 0.
- States: IDLE, FETCH, LOAD, SEND, GAP, DONE.
- IDLE:
  - cs_o=1.
  - start=1 with frame_len!=0: latch frame_len as remaining, rom_addr<=start_addr, frame_cnt<=0, err<=0, go to FETCH.
  - start=1 with frame_len==0: err<=0, go to DONE with no ROM access.
- FETCH: one cycle for ROM latency; go to LOAD.
- LOAD:
  - instrom<=rom_data.
  - cs_o<=0 on the same edge, so cs_o falls exactly when the new byte appears.
  - Go to SEND.
- SEND:
  - cs_o held 0; instrom stable.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - waddr==BITS sampled: cs_o<=1, frame_cnt+1, remaining-1, go to GAP.
  - Timeout counter reaches TMO_CYC first: err<=1, cs_o<=1, go to IDLE. No done pulse.
- GAP:
  - cs_o=1 for exactly GAP_CYC cycles.
  - Then, if remaining!=0: rom_addr<=rom_addr+1 (wraps 2^ROM_AW-1 -> 0), go to FETCH.
  - Else if loop_en=1: remaining<=latched frame_len, frame_cnt<=0, rom_addr<=start_addr, go to FETCH.
  - Else go to DONE.
- DONE: done=1 for one cycle, go to IDLE.
- abort=1:
  - Any state: next edge cs_o<=1, state<=IDLE.
  - frame_cnt and instrom hold; done not pulsed.
  - abort takes priority over start in IDLE and over completion in SEND.
- Per-frame latency: start -> first cs_o low = 3 edges (IDLE->FETCH->LOAD, cs_o falls at LOAD exit).
- Frame-to-frame: cs_o high for GAP_CYC+2 cycles (GAP + FETCH + LOAD).
- `waddr` is ignored outside SEND; a stale waddr==BITS while in GAP or FETCH has no effect.
- start while busy is ignored.
- Inputs start_addr and frame_len are used only when latched at start.
- The loop decision reuses the latched frame_len.

Test Plan:
- Reset mid-SEND:
  - Stimulus: assert rst=0 while cs_o=0.
  - Required: cs_o=1, busy=0, instrom=0 immediately, without waiting for a clock edge.
- Single frame:
  - Stimulus: start_addr=3, frame_len=1, ROM[3]=8'hAD; `wdata` model reaches waddr=8 after 9 cycles.
  - Required: rom_addr=3; instrom=8'hAD and cs_o falls together 3 cycles after start; cs_o rises 1 cycle after waddr=8; done pulses after GAP_CYC+1 cycles; frame_cnt=1.
- Address wrap:
  - Stimulus: start_addr=15, frame_len=3, ROM[15]=8'h11, ROM[0]=8'h22, ROM[1]=8'h33.
  - Required: instrom sequence 11,22,33; cs_o high exactly GAP_CYC+2 cycles between frames; frame_cnt=3; one done pulse.
- Loop:
  - Stimulus: frame_len=2, loop_en=1 for 5 frames, then loop_en=0.
  - Required: rom_addr repeats start_addr, start_addr+1; frame_cnt resets to 0 at each loop; done pulses only after the burst in progress when loop_en drops.
- Timeout:
  - Stimulus: waddr held at 0.
  - Required: after TMO_CYC cycles in SEND, err=1, cs_o=1, IDLE, no done; err stays 1 until the next start, then clears.
- Abort and empty burst:
  - Stimulus: abort during the 2nd frame's SEND.
  - Required: cs_o=1 next edge, IDLE, frame_cnt=1.
  - Stimulus: start with frame_len=0.
  - Required: done 2 cycles after start, cs_o never low.
